// File: rtl/apb_plic_slave_if_if.sv
// APB3 bus bundle between the APB bridge (master) and the PLIC register
// front-end (slave).
interface apb_plic_slave_if_if;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_plic_slave_if.sv
// APB3 slave front-end for the PLIC register file: decodes transfers into
// one-hot read/write strobes, waits on the register bank via reg_ready
// (bounded by TIMEOUT), and reports decode faults and timeouts on PSLVERR.
module apb_plic_slave_if #(
    parameter int                  NUM_REGS    = 10,
    parameter logic [31:0]         ADDR_OFFSET = 32'h0000_0000,
    parameter logic [NUM_REGS-1:0] RO_MASK     = {NUM_REGS{1'b0}},
    parameter int                  TIMEOUT     = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    apb_plic_slave_if_if.slave       apb,
    input  logic [NUM_REGS-1:0][31:0] read_data,
    input  logic                     reg_ready,
    output logic [NUM_REGS-1:0]      w_enable,
    output logic [NUM_REGS-1:0]      r_enable,
    output logic [31:0]              w_data
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic                write_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [31:0]         prdata_q;
    logic                pready_q;
    logic                pslverr_q;
    logic [NUM_REGS-1:0] w_enable_q;
    logic [NUM_REGS-1:0] r_enable_q;
    logic [31:0]         w_data_q;

    logic [32:0]         diff_d;
    logic [31:0]         off_d;
    logic [IDX_W-1:0]    idx_d;
    logic [NUM_REGS-1:0] sel_d;
    logic                ro_d;
    logic                hit_d;
    logic                legal_d;
    logic [31:0]         rd_sel;

    // Address decode: a borrow out of the 33-bit subtraction means PADDR is
    // below the window; sel_d is empty when the word index is out of range.
    always_comb begin
        diff_d = {1'b0, apb.PADDR} - {1'b0, ADDR_OFFSET};
        off_d  = diff_d[31:0];
        idx_d  = '0;
        sel_d  = '0;
        ro_d   = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (off_d[31:2] == 30'(i)) begin
                idx_d    = IDX_W'(i);
                sel_d[i] = 1'b1;
                ro_d     = RO_MASK[i];
            end
        end
        hit_d   = !diff_d[32] && (off_d[1:0] == 2'b00) && (|sel_d);
        legal_d = hit_d && !(apb.PWRITE && ro_d);
    end

    // Read-data mux on the index captured at setup.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_q == IDX_W'(i)) rd_sel = read_data[i];
        end
    end

    // Transfer FSM; strobes, PREADY and PSLVERR default low so each is a
    // single-cycle pulse, PRDATA only moves on DONE (reads) or ERROR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            write_q    <= 1'b0;
            cnt_q      <= '0;
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            w_enable_q <= '0;
            r_enable_q <= '0;
            w_data_q   <= '0;
        end else begin
            w_enable_q <= '0;
            r_enable_q <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (apb.PSEL && !apb.PENABLE) begin
                        idx_q    <= idx_d;
                        write_q  <= apb.PWRITE;
                        w_data_q <= apb.PWDATA;
                        if (legal_d) begin
                            state_q <= S_ACCESS;
                            if (apb.PWRITE) w_enable_q <= sel_d;
                            else            r_enable_q <= sel_d;
                        end else begin
                            state_q   <= S_ERROR;
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
                            prdata_q  <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!apb.PSEL) begin
                        state_q <= S_IDLE;
                    end else if (reg_ready) begin
                        if (!write_q) prdata_q <= rd_sel;
                        pready_q <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!apb.PSEL) begin
                        state_q <= S_IDLE;
                    end else if (reg_ready) begin
                        if (!write_q) prdata_q <= rd_sel;
                        pready_q <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b1;
                        prdata_q  <= '0;
                        state_q   <= S_ERROR;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                S_ERROR: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign w_enable    = w_enable_q;
    assign r_enable    = r_enable_q;
    assign w_data      = w_data_q;

endmodule

// File: doc/apb_plic_slave_if.md
# apb_plic_slave_if

Parametrised APB slave front-end for the PLIC register file: decodes APB3 transfers into one-hot read/write strobes for `NUM_REGS` word registers, supports slave-side wait states, and signals errors with `PSLVERR`. It replaces the fixed zero-wait, error-less decoder. It sits between the APB bridge and the PLIC gateway/claim register banks.

## Interface
- `NUM_REGS`, 10, number of 32-bit word registers mapped
- `ADDR_OFFSET`, 32'h0000_0000, byte address of register 0; must be word-aligned
- `RO_MASK`, {NUM_REGS{1'b0}}, bit i = 1 makes register i read-only
- `TIMEOUT`, 15, maximum wait cycles on `reg_ready` before the transfer errors; must be ≥ 1
- `clk` in 1 system clock, rising edge
- `rst` in 1 reset; asynchronous and active-high
- `PADDR` in 32 APB address
- `PWDATA` in 32 APB write data
- `PWRITE` in 1 APB direction, 1 = write
- `PSEL` in 1 APB select
- `PENABLE` in 1 APB enable
- `PRDATA` out 32 APB read data, registered
- `PREADY` out 1 transfer complete, registered
- `PSLVERR` out 1 transfer error; valid only while `PREADY`=1
- `read_data` in [NUM_REGS-1:0][31:0] register contents
- `reg_ready` in 1 register bank accepted/produced data this cycle
- `w_enable` out NUM_REGS one-hot write strobe
- `r_enable` out NUM_REGS one-hot read strobe
- `w_data` out 32 write data, held for the whole transfer

## Operation
- Decode, combinational from `PADDR`: `off = PADDR - ADDR_OFFSET`, 32-bit unsigned. Hit iff `PADDR >= ADDR_OFFSET`, `off[1:0]==0`, and `off>>2 < NUM_REGS`. Index width is `max(1,$clog2(NUM_REGS))`.
- Legal = hit and not (`PWRITE` and `RO_MASK[idx]`).
- FSM states:
  - IDLE. When `PSEL`=1 and `PENABLE`=0 (setup), latch index, direction, and `PWDATA`→`w_data`. Go to ACCESS if the transfer is legal, else to ERROR.
  - ACCESS. Assert exactly one of `w_enable[idx]`/`r_enable[idx]` for this one cycle only.
    - If `reg_ready`=1: latch `read_data[idx]` into `PRDATA` (reads), then go to DONE.
    - Else clear the wait counter and go to WAIT.
  - WAIT. Strobes stay low. The counter increments each cycle.
    - If `reg_ready`=1: latch read data, then go to DONE.
    - Else if the counter reaches `TIMEOUT`-1: go to ERROR.
  - DONE. `PREADY`=1, `PSLVERR`=0, then go to IDLE.
  - ERROR. `PREADY`=1, `PSLVERR`=1, `PRDATA`=0, then go to IDLE.
- `reg_ready` and `TIMEOUT` expiry in the same WAIT cycle: `reg_ready` wins, and the transfer goes to DONE.
- `PSEL` dropping in ACCESS or WAIT is a protocol abort. Go to IDLE next cycle with no `PREADY`, no further strobes, and `PRDATA` unchanged.
- A write takes effect only through its single `w_enable` pulse. An errored transfer never pulses any strobe.
- `PRDATA` keeps its last value outside DONE/ERROR.

## Timing
- Reset values of all outputs are 0: `PRDATA`, `PREADY`, `PSLVERR`, `w_enable`, `r_enable`, `w_data`. FSM resets to IDLE, counter to 0.
- Assertion of `rst` mid-transfer clears everything immediately, without waiting for a clock edge. No strobe fires after `rst` rises.
- Fastest transfer is 3 cycles:
  - cycle 0: setup, in IDLE
  - cycle 1: ACCESS, strobe, `reg_ready`=1
  - cycle 2: DONE, `PREADY`=1
- Each WAIT cycle adds 1 cycle. Longest successful transfer: `reg_ready` in the last WAIT cycle, 3+TIMEOUT cycles.
- Errored transfer on a decode fault: ERROR in cycle 1, `PREADY`/`PSLVERR` high in cycle 1.
- Errored transfer on timeout: `PREADY`/`PSLVERR` in cycle 2+TIMEOUT.
- Back-to-back transfers: a new setup is accepted in the cycle after DONE/ERROR.
- `PREADY` and `PSLVERR` are single-cycle pulses.

## Test plan
- Write `PADDR`=ADDR_OFFSET+8, `PWDATA`=32'hDEAD_BEEF, `reg_ready`=1 → `w_enable`=10'b0000000100 for 1 cycle in cycle 1, `w_data`=DEADBEEF, `PREADY`=1 and `PSLVERR`=0 in cycle 2.
- Read register 9, `read_data[9]`=32'h1234_5678, `reg_ready` low for 3 cycles → `r_enable[9]` pulses once, `PREADY` in cycle 5, `PRDATA`=12345678.
- Read register 0 with `reg_ready` never high, TIMEOUT=15 → `PSLVERR`=1 and `PREADY`=1 in cycle 17, `PRDATA`=0.
- Error cases, each giving `PSLVERR`=1 in cycle 1 and no strobe:
  - `PADDR`=ADDR_OFFSET+40 (unmapped)
  - `PADDR`=ADDR_OFFSET+2 (misaligned)
  - write to a register with `RO_MASK` bit 3 set
- Assert `rst` during WAIT → all outputs 0 immediately, FSM in IDLE, next legal transfer completes normally.
- `PSEL` dropped in WAIT → no `PREADY`; a following setup is accepted on the next cycle.
